// File: rtl/qa_pkg.sv
// Shared definitions for the QA block family: default geometry of the
// requester arbiter and the error codes reported across the QA blocks.
package qa_pkg;

    localparam int DEF_WDTH      = 32;
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_LOG_N_REQ = 2;

    // Error codes shared by the QA blocks
    typedef enum logic [3:0] {
        QA_ERR_NONE     = 4'h0,
        QA_ERR_OVERFLOW = 4'h1,
        QA_ERR_UNDERRUN = 4'h2,
        QA_ERR_TIMEOUT  = 4'h3,
        QA_ERR_PROTOCOL = 4'h4
    } qa_err_e;

    // Index width needed to address n entries (at least 1 bit)
    function automatic int qa_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/qa_arbiter_if.sv
// Requester / buffer-write bundle for qa_arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters-plus-buffer side.
interface qa_arbiter_if
    import qa_pkg::*;
#(
    parameter int WDTH      = DEF_WDTH,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int LOG_N_REQ = DEF_LOG_N_REQ
);

    logic [N_REQ*WDTH-1:0] in_data;
    logic [N_REQ-1:0]      in_nd;
    logic                  out_ready;
    logic [N_REQ-1:0]      clear_overflow;
    logic [WDTH-1:0]       out_data;
    logic [LOG_N_REQ-1:0]  out_src;
    logic                  out_nd;
    logic [N_REQ-1:0]      overflow;

    modport slave (
        input  in_data,
        input  in_nd,
        input  out_ready,
        input  clear_overflow,
        output out_data,
        output out_src,
        output out_nd,
        output overflow
    );

    modport master (
        output in_data,
        output in_nd,
        output out_ready,
        output clear_overflow,
        input  out_data,
        input  out_src,
        input  out_nd,
        input  overflow
    );

endinterface

// File: rtl/qa_arbiter_rr_arbiter.sv
// Combinational round-robin selector: starting at ptr and searching upward
// with wrap-around, the first set bit of valid wins.
module rr_arbiter
    import qa_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int LOG_N_REQ = DEF_LOG_N_REQ
) (
    input  logic [N_REQ-1:0]     valid,
    input  logic [LOG_N_REQ-1:0] ptr,
    output logic [LOG_N_REQ-1:0] grant,
    output logic                 any_grant
);

    // Scan from ptr, wrapping, and latch the first valid index found
    always_comb begin
        int                   idx;
        logic [LOG_N_REQ-1:0] idx_l;
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_l     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx   = (int'(ptr) + k) % N_REQ;
            idx_l = LOG_N_REQ'(idx);
            if (!any_grant && valid[idx_l]) begin
                grant     = idx_l;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qa_arbiter.sv
// Round-robin arbiter merging N_REQ single-word requesters onto one buffer
// write port. Each requester has a one-entry holding register; a word that
// arrives while the holder is still occupied (and not being drained on that
// edge) is dropped and flagged in a sticky overflow bit.
module qa_arbiter
    import qa_pkg::*;
#(
    parameter int WDTH      = DEF_WDTH,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int LOG_N_REQ = DEF_LOG_N_REQ
) (
    input  logic         clk,
    input  logic         rst_n,
    qa_arbiter_if.slave  bus
);

    logic [WDTH-1:0]      hold_data [N_REQ];
    logic [N_REQ-1:0]     hold_valid;
    logic [N_REQ-1:0]     overflow_q;
    logic [LOG_N_REQ-1:0] ptr;
    logic [LOG_N_REQ-1:0] grant_idx;
    logic                 grant_any;
    logic                 fire;
    logic [N_REQ-1:0]     grant_vec;
    logic [N_REQ-1:0]     capture;
    logic [N_REQ-1:0]     ovf_set;
    logic [WDTH-1:0]      out_data_q;
    logic [LOG_N_REQ-1:0] out_src_q;
    logic                 out_nd_q;

    // Pointer advance with explicit wrap so non-power-of-two N_REQ works
    function automatic logic [LOG_N_REQ-1:0] wrap_next(input logic [LOG_N_REQ-1:0] idx);
        if (int'(idx) == N_REQ - 1) begin
            return '0;
        end
        return idx + LOG_N_REQ'(1);
    endfunction

    rr_arbiter #(
        .N_REQ     (N_REQ),
        .LOG_N_REQ (LOG_N_REQ)
    ) u_rr_arbiter (
        .valid     (hold_valid),
        .ptr       (ptr),
        .grant     (grant_idx),
        .any_grant (grant_any)
    );

    assign fire = grant_any & bus.out_ready;

    // One-hot of the holder drained this edge; a drained holder may refill
    // on the same edge, an occupied one that is not drained overflows
    always_comb begin
        grant_vec = '0;
        if (fire) begin
            grant_vec[grant_idx] = 1'b1;
        end
        capture = bus.in_nd & (~hold_valid | grant_vec);
        ovf_set = bus.in_nd & hold_valid & ~grant_vec;
    end

    // Holding-register occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= '0;
        end else begin
            hold_valid <= (hold_valid & ~grant_vec) | capture;
        end
    end

    // Holding-register payload; only meaningful while hold_valid is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (capture[i]) begin
                hold_data[i] <= bus.in_data[i*WDTH +: WDTH];
            end
        end
    end

    // Sticky overflow: a set on the same edge as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= ovf_set | (overflow_q & ~bus.clear_overflow);
        end
    end

    // Output word, source tag, strobe and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_src_q  <= '0;
            out_nd_q   <= 1'b0;
            ptr        <= '0;
        end else if (fire) begin
            out_data_q <= hold_data[grant_idx];
            out_src_q  <= grant_idx;
            out_nd_q   <= 1'b1;
            ptr        <= wrap_next(grant_idx);
        end else begin
            out_nd_q   <= 1'b0;
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.out_src  = out_src_q;
    assign bus.out_nd   = out_nd_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_qa_arbiter.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a behavioural model of the arbitration rules.
module tb_qa_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int LN = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Behavioural model state
    logic [W-1:0] m_word  [N];
    bit           m_full  [N];
    bit           m_ovf   [N];
    int           m_next;
    logic [W-1:0] m_data;
    int           m_src;
    bit           m_nd;

    qa_arbiter_if #(.WDTH(W), .N_REQ(N), .LOG_N_REQ(LN)) bus ();

    qa_arbiter #(.WDTH(W), .N_REQ(N), .LOG_N_REQ(LN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_word[i] = '0;
        end
        m_next = 0;
        m_data = '0;
        m_src  = 0;
        m_nd   = 1'b0;
    endtask

    // Apply one clock edge of the arbitration rules to the model
    task automatic model_edge();
        int g;
        g = -1;
        if (bus.out_ready) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_full[(m_next + k) % N]) g = (m_next + k) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.in_nd[i] && m_full[i] && g != i) m_ovf[i] = 1'b1;
            else if (bus.clear_overflow[i]) m_ovf[i] = 1'b0;
        end
        if (g >= 0) begin
            m_data    = m_word[g];
            m_src     = g;
            m_nd      = 1'b1;
            m_full[g] = 1'b0;
            m_next    = (g + 1) % N;
        end else begin
            m_nd = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.in_nd[i] && !m_full[i]) begin
                m_full[i] = 1'b1;
                m_word[i] = bus.in_data[i*W +: W];
            end
        end
    endtask

    function automatic logic [31:0] model_ovf();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_nd"},   32'(bus.out_nd),   32'(m_nd));
        chk({tag, "_data"}, bus.out_data,      m_data);
        chk({tag, "_src"},  32'(bus.out_src),  32'(m_src));
        chk({tag, "_ovf"},  32'(bus.overflow), model_ovf());
    endtask

    // One clock: model follows the inputs present before the edge
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        bus.in_nd          = '0;
        bus.clear_overflow = '0;
    endtask

    task automatic put(input int i, input logic [W-1:0] d);
        bus.in_nd[i]           = 1'b1;
        bus.in_data[i*W +: W]  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_data        = '0;
        bus.in_nd          = '0;
        bus.out_ready      = 1'b0;
        bus.clear_overflow = '0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fairness: all four at once from pointer 0
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) put(i, 32'h10 + 32'(i));
        tick("fair_cap");
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            tick("fair");
            chk("fair_order_src", 32'(bus.out_src), 32'(k));
            chk("fair_order_data", bus.out_data, 32'h10 + 32'(k));
        end
        tick("fair_end");

        // Single word through requester 2, two-cycle latency, one pulse
        put(2, 32'hDEADBEEF);
        tick("single_cap");
        chk("single_not_early", 32'(bus.out_nd), 32'd0);
        idle_inputs();
        tick("single_out");
        chk("single_word", bus.out_data, 32'hDEADBEEF);
        chk("single_src", 32'(bus.out_src), 32'd2);
        tick("single_pulse");
        chk("single_one_pulse", 32'(bus.out_nd), 32'd0);

        // Back-pressure with two held words
        bus.out_ready = 1'b0;
        put(1, 32'h0000_1111);
        put(3, 32'h0000_3333);
        tick("bp_cap");
        idle_inputs();
        for (int k = 0; k < 5; k++) tick("bp_hold");
        bus.out_ready = 1'b1;
        tick("bp_rel0");
        chk("bp_first_src", 32'(bus.out_src), 32'd3);
        tick("bp_rel1");
        chk("bp_second_src", 32'(bus.out_src), 32'd1);
        tick("bp_end");

        // Overflow on requester 1, then clear
        bus.out_ready = 1'b0;
        put(1, 32'hA);
        tick("ovf_a");
        put(1, 32'hB);
        tick("ovf_b");
        chk("ovf_set", 32'(bus.overflow[1]), 32'd1);
        idle_inputs();
        bus.out_ready = 1'b1;
        tick("ovf_rel");
        chk("ovf_held_word", bus.out_data, 32'hA);
        tick("ovf_none");
        bus.clear_overflow[1] = 1'b1;
        tick("ovf_clr");
        chk("ovf_cleared", 32'(bus.overflow[1]), 32'd0);
        idle_inputs();

        // Grant-and-refill on requester 0
        bus.out_ready = 1'b0;
        put(0, 32'h44);
        tick("refill_cap");
        bus.out_ready = 1'b1;
        put(0, 32'h55);
        tick("refill_grant");
        chk("refill_no_ovf", 32'(bus.overflow[0]), 32'd0);
        idle_inputs();
        tick("refill_out");
        chk("refill_word", bus.out_data, 32'h55);

        // Reset mid-stream with three words held and an overflow pending
        bus.out_ready = 1'b0;
        put(0, 32'h70);
        put(1, 32'h71);
        put(2, 32'h72);
        tick("rst_cap");
        idle_inputs();
        put(0, 32'h7F);
        tick("rst_ovf");
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick("rst_after");

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                bus.in_nd[i]          = ($urandom_range(0, 9) < 3);
                bus.in_data[i*W +: W] = $urandom;
                bus.clear_overflow[i] = ($urandom_range(0, 9) == 0);
            end
            tick("rand");
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        for (int k = 0; k < N + 1; k++) tick("drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
